// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the signals that connect the CPU memory stage, the loader/debug
// engine and the single-port data memory to dmem_arbiter.
//   cpu*  : CPU request fields in; grant, stall and read return out
//   ld*   : loader request fields and burst lock in; grant and read return out
//   mem*  : address, write data and write enable out; read data in
//   conflictCount : contention statistic out
// Modports: slave  = arbiter side
//           master = requesters/memory side (testbench or surrounding SoC)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              cpuReq;
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAdrx;
  logic [DATA_W-1:0] cpuWrData;
  logic              cpuGnt;
  logic              cpuStall;
  logic              cpuRdValid;
  logic [DATA_W-1:0] cpuRdData;

  logic              ldReq;
  logic              ldWrite;
  logic [ADDR_W-1:0] ldAdrx;
  logic [DATA_W-1:0] ldWrData;
  logic              ldLock;
  logic              ldGnt;
  logic              ldRdValid;
  logic [DATA_W-1:0] ldRdData;

  logic [ADDR_W-1:0] memAdrx;
  logic [DATA_W-1:0] memDataIn;
  logic              memWrite;
  logic [DATA_W-1:0] memDataOut;

  logic [15:0]       conflictCount;

  modport slave (
    input  cpuReq, cpuWrite, cpuAdrx, cpuWrData,
    output cpuGnt, cpuStall, cpuRdValid, cpuRdData,
    input  ldReq, ldWrite, ldAdrx, ldWrData, ldLock,
    output ldGnt, ldRdValid, ldRdData,
    output memAdrx, memDataIn, memWrite,
    input  memDataOut,
    output conflictCount
  );

  modport master (
    output cpuReq, cpuWrite, cpuAdrx, cpuWrData,
    input  cpuGnt, cpuStall, cpuRdValid, cpuRdData,
    output ldReq, ldWrite, ldAdrx, ldWrData, ldLock,
    input  ldGnt, ldRdValid, ldRdData,
    input  memAdrx, memDataIn, memWrite,
    output memDataOut,
    input  conflictCount
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU memory stage (priority)
// and the loader/debug engine. The loader is forced through after MAX_WAIT
// denied cycles, may hold a bounded burst lock of up to LOCK_MAX cycles, and
// read data (1-cycle memory latency) is returned to whichever side issued it.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset; all outputs are 0 while low
//   bus    : dmem_arbiter_if.slave (cpu*, ld*, mem*, conflictCount)
// Optional build macro:
//   DMEM_ARB_STATS_EN : when defined, conflictCount counts cycles in which
//                       both sides request (saturating); otherwise it is 0.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic            relock_q, relock_d;
  logic            tag_vld_q, tag_vld_d;
  logic            tag_id_q, tag_id_d;   // 0 = CPU, 1 = loader
  logic            cpu_gnt, ld_gnt;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;
    relock_d = relock_q;
    cpu_gnt  = 1'b0;
    ld_gnt   = 1'b0;

    case (state_q)
      ARB: begin
        if (bus.ldReq && (!bus.cpuReq || starve_q == SW'(MAX_WAIT))) ld_gnt = 1'b1;
        else if (bus.cpuReq)                                         cpu_gnt = 1'b1;
        if (ld_gnt && bus.ldLock && !relock_q) begin
          state_d = LOCK;
          lock_d  = LW'(1);
        end
      end
      LOCK: begin
        if (bus.ldReq)       ld_gnt  = 1'b1;
        else if (bus.cpuReq) cpu_gnt = 1'b1;
        if (!bus.ldLock || !bus.ldReq) begin
          state_d = ARB;
          lock_d  = '0;
        end else if (lock_q + LW'(1) == LW'(LOCK_MAX)) begin
          // Burst hit its limit: give the CPU a chance before any relock.
          state_d  = ARB;
          lock_d   = '0;
          relock_d = 1'b1;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = ARB;
    endcase

    if (bus.ldReq && !ld_gnt)
      starve_d = (starve_q == SW'(MAX_WAIT)) ? starve_q : starve_q + SW'(1);
    else
      starve_d = '0;

    // Any cycle with the lock request released re-arms locking.
    if (!bus.ldLock) relock_d = 1'b0;
  end

  // Read tag: remembers who owns the data the memory returns next cycle.
  always_comb begin
    tag_vld_d = (cpu_gnt && !bus.cpuWrite) || (ld_gnt && !bus.ldWrite);
    tag_id_d  = ld_gnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB;
      starve_q  <= '0;
      lock_q    <= '0;
      relock_q  <= 1'b0;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lock_q    <= lock_d;
      relock_q  <= relock_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  // Combinational outputs are gated by reset so nothing leaks while it is low.
  always_comb begin
    bus.cpuGnt     = reset & cpu_gnt;
    bus.ldGnt      = reset & ld_gnt;
    bus.cpuStall   = reset & bus.cpuReq & ~cpu_gnt;
    bus.memWrite   = 1'b0;
    bus.memAdrx    = '0;
    bus.memDataIn  = '0;
    if (reset && ld_gnt) begin
      bus.memWrite  = bus.ldWrite;
      bus.memAdrx   = bus.ldAdrx;
      bus.memDataIn = bus.ldWrData;
    end else if (reset && cpu_gnt) begin
      bus.memWrite  = bus.cpuWrite;
      bus.memAdrx   = bus.cpuAdrx;
      bus.memDataIn = bus.cpuWrData;
    end
    bus.cpuRdValid = reset & tag_vld_q & ~tag_id_q;
    bus.ldRdValid  = reset & tag_vld_q & tag_id_q;
    bus.cpuRdData  = bus.cpuRdValid ? bus.memDataOut : '0;
    bus.ldRdData   = bus.ldRdValid  ? bus.memDataOut : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (bus.cpuReq && bus.ldReq && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_q <= '0;
    else        conflict_q <= conflict_d;
  end

  assign bus.conflictCount = reset ? conflict_q : 16'd0;
`else
  assign bus.conflictCount = 16'd0;
`endif

endmodule
